pattern_scan_ctrl: RTL
======================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL provide parameter: PAT_W, 8, maximum pattern length in bits (2..16).
REQ-002 SHALL provide ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  configuration load strobe.
- cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  in  4  pattern length.
- cfg_overlap  in  1  1 = overlapping matches.
- cfg_max_hits  in  8  hit limit; 0 = unlimited.
- start  in  1  arm scan.
- abort  in  1  stop scan.
- stream_valid  in  1  stream_in qualifier.
- stream_in  in  1  serial data.
- busy  out  1  high in SCAN.
- pattern_found  out  1  one-cycle match pulse.
- hit_count  out  8  matches since last arm.
- done  out  1  hit limit reached.
- cfg_err  out  1  one-cycle config-reject pulse.

Function
REQ-003 SHALL implement a registered FSM with states IDLE, SCAN and DONE; busy=1 only in SCAN, and done=1 only in DONE.
REQ-004 IDLE: cfg_we with 1<=cfg_len<=PAT_W SHALL load all cfg_* registers; start SHALL enter SCAN, clearing the history shift register, fill counter and hit_count.
REQ-005 cfg_we in SCAN or DONE, or cfg_len outside 1..PAT_W, SHALL leave config unchanged and pulse cfg_err for one cycle.
REQ-006 SCAN: each clk edge with stream_valid=1 SHALL shift stream_in into the LSB of a PAT_W-bit history register; the fill counter SHALL increment and saturate at PAT_W.
REQ-007 Cycles with stream_valid=0 SHALL hold history, fill counter and outputs unchanged.
REQ-008 A match SHALL occur when the low cfg_len bits of the updated history equal cfg_pattern[cfg_len-1:0] and the updated fill counter is >= cfg_len.
REQ-009 On a match, pattern_found SHALL be high for exactly the one cycle following the sampling edge of the final bit. hit_count SHALL increment on that same edge and saturate at 255.
REQ-010 Overlap mode SHALL keep the fill counter after a match; non-overlap mode SHALL clear it to 0 on a match.
REQ-011 When cfg_max_hits!=0 and hit_count reaches cfg_max_hits, SCAN SHALL go to DONE on that edge; further stream bits are ignored.
REQ-012 DONE: start SHALL re-arm into SCAN, applying the REQ-004 clears; done SHALL stay high until then.
REQ-013 abort in SCAN or DONE SHALL go to IDLE, retain hit_count and clear history.
REQ-014 abort SHALL win over a simultaneous start, and abort SHALL win over a match completing on the same edge, which is not counted.
REQ-015 start while in SCAN SHALL be ignored.

Reset
REQ-016 reset_n=0 at a clk edge SHALL force IDLE from any state, including mid-scan.
REQ-017 On reset, busy, done, pattern_found and cfg_err SHALL be 0, and hit_count, history and fill counter SHALL be 0.
REQ-018 On reset, config SHALL be pattern=0x1A (11010), len=5, overlap=1, max_hits=0.

Configuration
REQ-019 With PATTERN_SCAN_OVERLAP_EN defined, cfg_overlap SHALL be honoured per REQ-010.
REQ-020 With PATTERN_SCAN_OVERLAP_EN undefined, the block SHALL always be non-overlapping, cfg_overlap SHALL be ignored and no overlap register SHALL exist.

Verification
REQ-021 Reset, start, then stream 1,1,0,1,0 valid every cycle -> pattern_found is a single pulse in the cycle after bit 5; hit_count=1; busy=1.
REQ-022 Load pattern=0b101 with len=3, then stream 1,0,1,0,1 -> with overlap=1, hit_count=2; with overlap=0 or the macro undefined, hit_count=1.
REQ-023 Set max_hits=2 and stream 11010 three times -> DONE after the 2nd match: done=1, busy=0, hit_count=2, and no third pulse.
REQ-024 Stream 1,1,0,1,0 with stream_valid=0 for 3 cycles between each bit -> exactly one match, and outputs are stable during the gaps.
REQ-025 Error and abort cases:
- cfg_we during SCAN, or cfg_len=0 in IDLE -> cfg_err pulses once and the config reads back unchanged.
- abort and start together in SCAN -> IDLE with hit_count retained.
REQ-026 reset_n=0 for one edge mid-match-sequence -> all outputs 0, state IDLE, config restored to 0x1A/5.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: matches a configurable bit pattern in a qualified stream and counts hits.
// Optional feature: define PATTERN_SCAN_OVERLAP_EN to honour cfg_overlap (otherwise always non-overlapping).
module pattern_scan_ctrl #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [7:0]       cfg_max_hits,
  input  logic             start,
  input  logic             abort,
  input  logic             stream_valid,
  input  logic             stream_in,
  output logic             busy,
  output logic             pattern_found,
  output logic [7:0]       hit_count,
  output logic             done,
  output logic             cfg_err
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  hist_q, hist_d, hist_upd, len_mask;
  logic [FILL_W-1:0] fill_q, fill_d, fill_upd;
  logic [7:0]        hit_count_q, hit_count_d;
  logic              found_q, found_d;
  logic              cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0]  cfg_pattern_q, cfg_pattern_d;
  logic [3:0]        cfg_len_q, cfg_len_d;
  logic [7:0]        cfg_max_hits_q, cfg_max_hits_d;
  logic              overlap_en, len_ok, match;

`ifdef PATTERN_SCAN_OVERLAP_EN
  logic cfg_overlap_q, cfg_overlap_d;
  assign overlap_en = cfg_overlap_q;
`else
  logic unused_cfg_overlap;
  assign unused_cfg_overlap = cfg_overlap;
  assign overlap_en         = 1'b0;
`endif

  assign len_ok   = (cfg_len != 4'd0) && (int'(cfg_len) <= PAT_W);
  assign hist_upd = {hist_q[PAT_W-2:0], stream_in};
  assign fill_upd = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(cfg_len_q));
    end
  end

  // Compare only the low cfg_len bits; the newest bit sits in the LSB.
  assign match = (((hist_upd ^ cfg_pattern_q) & len_mask) == '0) &&
                 (int'(fill_upd) >= int'(cfg_len_q));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    hist_d         = hist_q;
    fill_d         = fill_q;
    hit_count_d    = hit_count_q;
    found_d        = 1'b0;
    cfg_err_d      = cfg_we && ((state_q != IDLE) || !len_ok);
    cfg_pattern_d  = cfg_pattern_q;
    cfg_len_d      = cfg_len_q;
    cfg_max_hits_d = cfg_max_hits_q;
`ifdef PATTERN_SCAN_OVERLAP_EN
    cfg_overlap_d  = cfg_overlap_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (cfg_we && len_ok) begin
          cfg_pattern_d  = cfg_pattern;
          cfg_len_d      = cfg_len;
          cfg_max_hits_d = cfg_max_hits;
`ifdef PATTERN_SCAN_OVERLAP_EN
          cfg_overlap_d  = cfg_overlap;
`endif
        end
        if (start && !abort) begin
          state_d     = SCAN;
          hist_d      = '0;
          fill_d      = '0;
          hit_count_d = '0;
        end
      end

      SCAN: begin
        if (abort) begin
          // A match completing on this edge is dropped along with the history.
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (stream_valid) begin
          hist_d = hist_upd;
          fill_d = fill_upd;
          if (match) begin
            found_d     = 1'b1;
            hit_count_d = (hit_count_q == 8'hFF) ? hit_count_q : hit_count_q + 8'd1;
            if (!overlap_en) begin
              fill_d = '0;
            end
            if ((cfg_max_hits_q != 8'd0) && (hit_count_d == cfg_max_hits_q)) begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        if (abort) begin
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end else if (start) begin
          state_d     = SCAN;
          hist_d      = '0;
          fill_d      = '0;
          hit_count_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q        <= IDLE;
      hist_q         <= '0;
      fill_q         <= '0;
      hit_count_q    <= '0;
      found_q        <= 1'b0;
      cfg_err_q      <= 1'b0;
      cfg_pattern_q  <= PAT_W'(5'b11010);
      cfg_len_q      <= 4'd5;
      cfg_max_hits_q <= 8'd0;
`ifdef PATTERN_SCAN_OVERLAP_EN
      cfg_overlap_q  <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      hist_q         <= hist_d;
      fill_q         <= fill_d;
      hit_count_q    <= hit_count_d;
      found_q        <= found_d;
      cfg_err_q      <= cfg_err_d;
      cfg_pattern_q  <= cfg_pattern_d;
      cfg_len_q      <= cfg_len_d;
      cfg_max_hits_q <= cfg_max_hits_d;
`ifdef PATTERN_SCAN_OVERLAP_EN
      cfg_overlap_q  <= cfg_overlap_d;
`endif
    end
  end

  assign busy          = (state_q == SCAN);
  assign done          = (state_q == DONE);
  assign pattern_found = found_q;
  assign hit_count     = hit_count_q;
  assign cfg_err       = cfg_err_q;

endmodule
